// File: rtl/ram_ctrl4x4_pkg.sv
// Shared sizes and FSM state encoding for the 4x4 RAM access controller.
package ram_ctrl4x4_pkg;

  localparam int unsigned WORDS  = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 8;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StSetup = 3'd1;
  localparam state_t StWrite = 3'd2;
  localparam state_t StRead  = 3'd3;
  localparam state_t StDone  = 3'd4;

endpackage

// File: rtl/ram_ctrl4x4_addr_dec2to4.sv
// Combinational 2-to-4 one-hot word decoder with enable.
module addr_dec2to4
  import ram_ctrl4x4_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [WORDS-1:0]  sel
);

  always_comb begin
    sel = '0;
    if (en) begin
      sel[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_ctrl4x4.sv
// Sequences single-word accesses to four external 4-bit storage cells:
// IDLE -> SETUP -> WRITE/READ -> DONE -> IDLE, one access every 4 cycles.
module ram_ctrl4x4
  import ram_ctrl4x4_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [WORDS-1:0]  sel,
  output logic              wr_en,
  output logic [DATA_W-1:0] data_bus,
  input  logic [DATA_W-1:0] rd_bus,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ack_we,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  state_t              state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ready_q, wr_en_q, ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    wr_cnt_q, rd_cnt_q;
  logic                accept;
  logic                dec_en;

  assign accept = (state_q == StIdle) && req && ready_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StSetup;
      StSetup: state_d = we_q ? StWrite : StRead;
      StWrite: state_d = StDone;
      StRead:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StIdle);
      wr_en_q <= (state_d == StWrite);
      ack_q   <= (state_d == StDone);
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state_q == StWrite && wr_cnt_q != '1) begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
      if (state_q == StRead) begin
        rdata_q <= rd_bus;
        if (rd_cnt_q != '1) begin
          rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Select is gated by the registered state so clear drops it without a clock.
  assign dec_en = (state_q == StSetup) || (state_q == StWrite) || (state_q == StRead);

  addr_dec2to4 u_dec (
    .en   (dec_en),
    .addr (addr_q),
    .sel  (sel)
  );

  assign ready    = ready_q;
  assign wr_en    = wr_en_q;
  assign data_bus = wdata_q;
  assign ack      = ack_q;
  assign ack_we   = we_q;
  assign rdata    = rdata_q;
  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;

endmodule

// File: tb/tb_ram_ctrl4x4.sv
// Directed bench for ram_ctrl4x4 with four gated-clock storage cells on the bus.
module tb_ram_ctrl4x4;

  logic       clk, clear, req, we;
  logic [1:0] addr;
  logic [3:0] wdata;
  logic       ready, wr_en, ack, ack_we;
  logic [3:0] sel, data_bus, rd_bus, rdata;
  logic [7:0] wr_count, rd_count;

  logic [3:0] mem [4];
  logic [3:0] gclk;

  int checks;
  int failures;

  ram_ctrl4x4 dut (
    .clk      (clk),
    .clear    (clear),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .sel      (sel),
    .wr_en    (wr_en),
    .data_bus (data_bus),
    .rd_bus   (rd_bus),
    .ack      (ack),
    .rdata    (rdata),
    .ack_we   (ack_we),
    .wr_count (wr_count),
    .rd_count (rd_count)
  );

  for (genvar n = 0; n < 4; n++) begin : g_cell
    assign gclk[n] = clk & wr_en & sel[n];
    always @(posedge gclk[n]) mem[n] <= data_bus;
  end

  assign rd_bus = (mem[0] & {4{sel[0]}}) | (mem[1] & {4{sel[1]}}) |
                  (mem[2] & {4{sel[2]}}) | (mem[3] & {4{sel[3]}});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns 1 ns after the accepting edge, with the inputs scrambled.
  task automatic start_access(input logic w, input logic [1:0] a, input logic [3:0] d);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", ready, 1);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
  endtask

  task automatic run_access(input logic w, input logic [1:0] a, input logic [3:0] d,
                            input logic [3:0] exp_rd);
    logic [3:0] oh;
    oh = 4'b0001 << a;
    start_access(w, a, d);
    check($sformatf("setup_sel a=%0d", a), sel, oh);
    check("setup_ready", ready, 0);
    check("setup_wr_en", wr_en, 0);
    if (w) check("setup_data_bus", data_bus, d);
    @(posedge clk); #1;
    check("mid_wr_en", wr_en, w);
    check($sformatf("mid_sel a=%0d", a), sel, oh);
    check("mid_ack", ack, 0);
    @(posedge clk); #1;
    check("done_ack", ack, 1);
    check("done_ack_we", ack_we, w);
    check("done_wr_en", wr_en, 0);
    check("done_sel", sel, 0);
    if (!w) check($sformatf("done_rdata a=%0d", a), rdata, exp_rd);
    @(posedge clk); #1;
    check("idle_ack", ack, 0);
    check("idle_ready", ready, 1);
  endtask

  initial begin
    checks = 0; failures = 0;
    clear = 1'b1; req = 1'b0; we = 1'b0; addr = 2'd0; wdata = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 0);
    check("rst_sel", sel, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_data_bus", data_bus, 0);
    check("rst_ack", ack, 0);
    check("rst_ack_we", ack_we, 0);
    check("rst_rdata", rdata, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_count", rd_count, 0);
    @(negedge clk); clear = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", ready, 1);

    // Single write then read back of word 2
    run_access(1'b1, 2'd2, 4'b1011, 4'b0000);
    check("wr_count_1", wr_count, 1);
    run_access(1'b0, 2'd2, 4'b0000, 4'b1011);
    check("rd_count_1", rd_count, 1);

    // Walking-one pattern into every word, then read all back
    for (int i = 0; i < 4; i++) run_access(1'b1, 2'(i), 4'b0001 << i, 4'b0000);
    for (int i = 0; i < 4; i++) run_access(1'b0, 2'(i), 4'b0000, 4'b0001 << i);
    check("wr_count_5", wr_count, 5);
    check("rd_count_5", rd_count, 5);

    // req held high: accepts only when ready, later addr/we changes ignored
    req = 1'b1; we = 1'b0; addr = 2'd1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold_ready k=%0d", k), ready, (k % 4 == 0));
      check($sformatf("hold_ack k=%0d", k), ack, (k % 4 == 3));
      if (k % 4 == 3) check($sformatf("hold_rdata k=%0d", k), rdata, 4'b0010);
      addr = (k % 4 == 0) ? 2'd1 : 2'd3;
      we   = (k % 4 != 0);
    end
    req = 1'b0; we = 1'b0;
    check("hold_rd_count", rd_count, 8);
    check("hold_wr_count", wr_count, 5);

    // clear during WRITE aborts asynchronously
    start_access(1'b1, 2'd0, 4'b1111);
    @(posedge clk); #1;
    check("abort_w_wr_en_before", wr_en, 1);
    #2 clear = 1'b1;
    #1;
    check("abort_w_wr_en", wr_en, 0);
    check("abort_w_sel", sel, 0);
    @(posedge clk); #1;
    check("abort_w_ack", ack, 0);
    @(negedge clk); clear = 1'b0;
    @(posedge clk); #1;
    check("abort_w_wr_count", wr_count, 0);
    check("abort_w_ready", ready, 1);

    // clear during READ: nothing captured
    start_access(1'b0, 2'd1, 4'b0000);
    @(posedge clk); #1;
    check("abort_r_sel_before", sel, 4'b0010);
    #2 clear = 1'b1;
    #1;
    check("abort_r_sel", sel, 0);
    @(posedge clk); #1;
    @(negedge clk); clear = 1'b0;
    @(posedge clk); #1;
    check("abort_r_ack", ack, 0);
    check("abort_r_rdata", rdata, 0);
    check("abort_r_rd_count", rd_count, 0);

    // Saturation of the write counter
    for (int i = 0; i < 260; i++) run_access(1'b1, 2'(i), 4'(i), 4'b0000);
    check("wr_count_sat", wr_count, 255);
    check("rd_count_after_sat", rd_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
